// File: rtl/pipe_adder_nbit.sv
// pipe_adder_nbit: pipelined ripple-carry adder/subtractor, one SEG-bit segment per stage; define ADDER_SAT_EN to clamp S on signed overflow
module pipe_adder_nbit #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf
);
   localparam int STAGES = WIDTH / SEG;
   localparam int L = STAGES - 1;

   if (WIDTH % SEG != 0) begin : g_bad_width
      $error("pipe_adder_nbit: WIDTH must be a multiple of SEG");
   end

   logic stall;
   logic out_valid_q, cout_q, ovf_q;
   logic [WIDTH-1:0] s_q;
   logic [WIDTH-1:0] res_d;
   logic ovf_d;

   // The whole pipe moves together; a held result freezes every stage behind it.
   assign stall = out_valid_q && !out_ready;
   assign in_ready = !stall && !rst;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      // Only operand bits not yet consumed travel on; bit 0 is this stage's segment.
      localparam int AW = WIDTH - k * SEG;
      logic [AW-1:0] a_in, b_in;
      logic [WIDTH-1:0] s_in, s_d;
      logic c_in, v_in, c_d;
      if (k == 0) begin : g_src
         assign a_in = A;
         assign b_in = sub ? ~B : B;
         assign s_in = '0;
         assign c_in = sub ? ~Cin : Cin;
         assign v_in = in_valid;
      end else begin : g_src
         assign a_in = g_st[k-1].g_reg.a_q;
         assign b_in = g_st[k-1].g_reg.b_q;
         assign s_in = g_st[k-1].g_reg.s_q;
         assign c_in = g_st[k-1].g_reg.c_q;
         assign v_in = g_st[k-1].g_reg.v_q;
      end
      // Ripple this stage's SEG full adders and splice the segment into the partial sum.
      always_comb begin
         logic cy;
         cy = c_in;
         s_d = s_in;
         for (int i = 0; i < SEG; i++) begin
            s_d[k*SEG+i] = a_in[i] ^ b_in[i] ^ cy;
            cy = (a_in[i] & b_in[i]) | (cy & (a_in[i] ^ b_in[i]));
         end
         c_d = cy;
      end
      if (k < L) begin : g_reg
         logic [AW-SEG-1:0] a_q, b_q;
         logic [WIDTH-1:0] s_q;
         logic c_q, v_q;
         // Stage register: bubbles pass through as v_q=0, nothing moves while stalled.
         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
               s_q <= '0;
               c_q <= 1'b0;
               v_q <= 1'b0;
            end else if (!stall) begin
               a_q <= a_in[AW-1:SEG];
               b_q <= b_in[AW-1:SEG];
               s_q <= s_d;
               c_q <= c_d;
               v_q <= v_in;
            end
         end
      end
   end

   // Signed overflow from the operand signs seen by the adder (B already inverted for sub).
   always_comb begin
      ovf_d = (g_st[L].a_in[SEG-1] == g_st[L].b_in[SEG-1]) && (g_st[L].s_d[WIDTH-1] != g_st[L].a_in[SEG-1]);
`ifdef ADDER_SAT_EN
      res_d = !ovf_d ? g_st[L].s_d : g_st[L].a_in[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
      res_d = g_st[L].s_d;
`endif
   end

   // Output register closes the last stage; contents hold until the consumer takes them.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         s_q <= '0;
         cout_q <= 1'b0;
         ovf_q <= 1'b0;
      end else if (!stall) begin
         out_valid_q <= g_st[L].v_in;
         s_q <= res_d;
         cout_q <= g_st[L].c_d;
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign S = s_q;
   assign Cout = cout_q;
   assign Ovf = ovf_q;
endmodule

// File: tb/tb_pipe_adder_nbit.sv
// tb_pipe_adder_nbit: scoreboard bench for pipe_adder_nbit (WIDTH=16, SEG=4)
module tb_pipe_adder_nbit;
   logic clk = 1'b0;
   logic rst, in_valid, in_ready, Cin, sub, out_valid, out_ready, Cout, Ovf;
   logic [15:0] A, B, S;
   int n_vec = 0, n_err = 0, cyc = 0;
   bit tog = 1'b0;

   typedef struct {
      logic [15:0] s;
      logic c;
      logic o;
      int acyc;
      bit lc;
   } exp_t;
   exp_t sb[$];

   pipe_adder_nbit #(.WIDTH(16), .SEG(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Cin(Cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .S(S), .Cout(Cout), .Ovf(Ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb_i);
      logic [15:0] bb;
      logic [16:0] r;
      exp_t e;
      bb = sb_i ? ~b : b;
      r = {1'b0, a} + {1'b0, bb} + {16'd0, sb_i ? ~ci : ci};
      e.s = r[15:0];
      e.c = r[16];
      e.o = (a[15] == bb[15]) && (r[15] != a[15]);
`ifdef ADDER_SAT_EN
      if (e.o) e.s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
      e.acyc = 0;
      e.lc = 1'b0;
      return e;
   endfunction

   // Present a beat and hold it until accepted; expectation is queued at the accepting cycle.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb_i, input bit lc);
      int t;
      exp_t e;
      A = a;
      B = b;
      Cin = ci;
      sub = sb_i;
      in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (t >= 50) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      e = model(a, b, ci, sb_i);
      e.acyc = cyc;
      e.lc = lc;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("drain", sb.size(), 0);
   endtask

   // out_ready pattern for the streaming test: 3 cycles on, 3 off.
   initial forever begin
      @(posedge clk);
      #1;
      if (tog) out_ready = ((cyc / 3) % 2) == 0;
   end

   // Monitor: handshake rule, hold-during-stall, and in-order scoreboard compare.
   logic prev_stall = 1'b0;
   logic [15:0] prev_s;
   logic prev_c, prev_o;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
         if (prev_stall) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_S", {16'd0, S}, {16'd0, prev_s});
            chk("hold_Cout", {31'd0, Cout}, {31'd0, prev_c});
            chk("hold_Ovf", {31'd0, Ovf}, {31'd0, prev_o});
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("S", {16'd0, S}, {16'd0, e.s});
               chk("Cout", {31'd0, Cout}, {31'd0, e.c});
               chk("Ovf", {31'd0, Ovf}, {31'd0, e.o});
               if (e.lc) chk("latency", cyc - e.acyc, 32'd4);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_s = S;
         prev_c = Cout;
         prev_o = Ovf;
      end
   end

   logic [15:0] dv_a [6] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h8000, 16'h7FFF, 16'h8000};
   logic [15:0] dv_b [6] = '{16'h4321, 16'h0000, 16'h0007, 16'h0001, 16'h0001, 16'h8000};
   logic        dv_c [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   logic        dv_s [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      A = '0;
      B = '0;
      Cin = 1'b0;
      sub = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_S", {16'd0, S}, 32'd0);
      chk("rst_Cout", {31'd0, Cout}, 32'd0);
      chk("rst_Ovf", {31'd0, Ovf}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Directed vectors, one at a time so each result's latency is exact.
      for (int i = 0; i < 6; i++) begin
         send(dv_a[i], dv_b[i], dv_c[i], dv_s[i], 1'b1);
         in_valid = 1'b0;
         drain();
         @(posedge clk);
         #1;
      end

      // Back-to-back random stream against a toggling consumer.
      tog = 1'b1;
      for (int i = 0; i < 8; i++)
         send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      in_valid = 1'b0;
      drain();
      tog = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      // Reset with three beats in flight: none of them may ever emerge.
      for (int i = 0; i < 3; i++)
         send(16'h1000 + 16'(i), 16'h0100, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      repeat (8) @(negedge clk);
      @(posedge clk);
      #1;
      send(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 1'b1);
      in_valid = 1'b0;
      drain();
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
